// File: rtl/rgb_colourspace_converter.sv
// SRAM-to-SRAM YUV 4:2:2 to interleaved RGB converter.
// Each 4-pixel group takes 16 cycles: read, wait, calculate, write.
module rgb_colourspace_converter #(
  parameter logic [17:0] Y_BASE     = 18'd0,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter logic [14:0] NUM_GROUPS = 15'd19200
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data
);

  typedef enum logic [4:0] {
    S_IDLE, S_RD_Y0, S_RD_Y1, S_RD_U, S_RD_V, S_RD_W0, S_RD_W1,
    S_CALC0, S_CALC1, S_CALC2, S_CALC3,
    S_WR0, S_WR1, S_WR2, S_WR3, S_WR4, S_WR5
  } state_t;

  state_t      state;
  logic [14:0] group;
  logic [15:0] y0_word, y1_word, u_word, v_word;
  logic [7:0]  r_pix [4];
  logic [7:0]  g_pix [4];
  logic [7:0]  b_pix [4];

  logic [17:0] group_ext, next_group_ext, y_addr, next_y_addr, u_addr, v_addr, rgb_addr;
  logic [14:0] next_group;

  assign next_group     = group + 15'd1;
  assign group_ext      = {3'd0, group};
  assign next_group_ext = {3'd0, next_group};
  assign y_addr         = Y_BASE + (group_ext << 1);
  assign next_y_addr    = Y_BASE + (next_group_ext << 1);
  assign u_addr         = U_BASE + group_ext;
  assign v_addr         = V_BASE + group_ext;
  assign rgb_addr       = RGB_BASE + (group_ext << 2) + (group_ext << 1);

  // Pick the luma/chroma bytes for the pixel being calculated this cycle.
  logic [7:0]  y_byte, u_byte, v_byte;
  logic [1:0]  calc_idx;
  always_comb begin
    y_byte   = y0_word[15:8];
    u_byte   = u_word[15:8];
    v_byte   = v_word[15:8];
    calc_idx = 2'd0;
    case (state)
      S_CALC1: begin
        y_byte   = y0_word[7:0];
        calc_idx = 2'd1;
      end
      S_CALC2: begin
        y_byte   = y1_word[15:8];
        u_byte   = u_word[7:0];
        v_byte   = v_word[7:0];
        calc_idx = 2'd2;
      end
      S_CALC3: begin
        y_byte   = y1_word[7:0];
        u_byte   = u_word[7:0];
        v_byte   = v_word[7:0];
        calc_idx = 2'd3;
      end
      default: ;
    endcase
  end

  function automatic logic [7:0] clip(input logic signed [31:0] x);
    if (x < 0)
      return 8'd0;
    else if (x > 32'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

  logic signed [31:0] y_s, u_s, v_s, r_full, g_full, b_full;
  always_comb begin
    y_s    = $signed({24'd0, y_byte}) - 32'sd16;
    u_s    = $signed({24'd0, u_byte}) - 32'sd128;
    v_s    = $signed({24'd0, v_byte}) - 32'sd128;
    r_full = (32'sd76284 * y_s + 32'sd104595 * v_s) >>> 16;
    g_full = (32'sd76284 * y_s - 32'sd25624 * u_s - 32'sd53281 * v_s) >>> 16;
    b_full = (32'sd76284 * y_s + 32'sd132251 * u_s) >>> 16;
  end

  // SRAM address/data/we_n are registered on entry to each state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state           <= S_IDLE;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      group           <= 15'd0;
      y0_word         <= 16'd0;
      y1_word         <= 16'd0;
      u_word          <= 16'd0;
      v_word          <= 16'd0;
      for (int k = 0; k < 4; k++) begin
        r_pix[k] <= 8'd0;
        g_pix[k] <= 8'd0;
        b_pix[k] <= 8'd0;
      end
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && !Done) begin
            Busy         <= 1'b1;
            group        <= 15'd0;
            SRAM_address <= Y_BASE;
            state        <= S_RD_Y0;
          end
        end
        S_RD_Y0: begin
          SRAM_address <= y_addr + 18'd1;
          state        <= S_RD_Y1;
        end
        S_RD_Y1: begin
          SRAM_address <= u_addr;
          state        <= S_RD_U;
        end
        S_RD_U: begin
          y0_word      <= SRAM_read_data;
          SRAM_address <= v_addr;
          state        <= S_RD_V;
        end
        S_RD_V: begin
          y1_word <= SRAM_read_data;
          state   <= S_RD_W0;
        end
        S_RD_W0: begin
          u_word <= SRAM_read_data;
          state  <= S_RD_W1;
        end
        S_RD_W1: begin
          v_word <= SRAM_read_data;
          state  <= S_CALC0;
        end
        S_CALC0, S_CALC1, S_CALC2, S_CALC3: begin
          r_pix[calc_idx] <= clip(r_full);
          g_pix[calc_idx] <= clip(g_full);
          b_pix[calc_idx] <= clip(b_full);
          if (state == S_CALC3) begin
            SRAM_we_n       <= 1'b0;
            SRAM_address    <= rgb_addr;
            SRAM_write_data <= {r_pix[0], g_pix[0]};
            state           <= S_WR0;
          end else begin
            state <= state_t'(state + 5'd1);
          end
        end
        S_WR0: begin
          SRAM_address    <= rgb_addr + 18'd1;
          SRAM_write_data <= {b_pix[0], r_pix[1]};
          state           <= S_WR1;
        end
        S_WR1: begin
          SRAM_address    <= rgb_addr + 18'd2;
          SRAM_write_data <= {g_pix[1], b_pix[1]};
          state           <= S_WR2;
        end
        S_WR2: begin
          SRAM_address    <= rgb_addr + 18'd3;
          SRAM_write_data <= {r_pix[2], g_pix[2]};
          state           <= S_WR3;
        end
        S_WR3: begin
          SRAM_address    <= rgb_addr + 18'd4;
          SRAM_write_data <= {b_pix[2], r_pix[3]};
          state           <= S_WR4;
        end
        S_WR4: begin
          SRAM_address    <= rgb_addr + 18'd5;
          SRAM_write_data <= {g_pix[3], b_pix[3]};
          state           <= S_WR5;
        end
        S_WR5: begin
          SRAM_we_n       <= 1'b1;
          SRAM_write_data <= 16'd0;
          if (group == NUM_GROUPS - 15'd1) begin
            Busy         <= 1'b0;
            Done         <= 1'b1;
            SRAM_address <= 18'd0;
            state        <= S_IDLE;
          end else begin
            group        <= next_group;
            SRAM_address <= next_y_addr;
            state        <= S_RD_Y0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_colourspace_converter.sv
// Bench for rgb_colourspace_converter: a small image placed so the last RGB
// write lands on address 262143, checked cycle by cycle against a pixel model.
module tb_rgb_colourspace_converter;

  localparam int          N      = 4;
  localparam logic [17:0] Y_B    = 18'd0;
  localparam logic [17:0] U_B    = 18'd38400;
  localparam logic [17:0] V_B    = 18'd57600;
  localparam logic [17:0] RGB_B  = 18'd262144 - 18'd24;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic        Busy;
  logic        Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;

  logic [15:0] mem [0:262143];
  logic [15:0] read_pipe;

  int checkCount = 0;
  int errorCount = 0;

  rgb_colourspace_converter #(
    .Y_BASE(Y_B), .U_BASE(U_B), .V_BASE(V_B), .RGB_BASE(RGB_B),
    .NUM_GROUPS(15'(N))
  ) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .Busy(Busy),
    .Done(Done),
    .SRAM_address(SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n),
    .SRAM_read_data(SRAM_read_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Two-cycle read latency SRAM (reads only; writes are checked, not stored).
  always @(posedge Clock) begin
    read_pipe      <= mem[SRAM_address];
    SRAM_read_data <= read_pipe;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int clip8(input int x);
    return (x < 0) ? 0 : ((x > 255) ? 255 : x);
  endfunction

  // Expected RGB word i of group g, from the YUV data in memory.
  function automatic logic [15:0] expWord(input int g, input int i);
    logic [7:0]  stream [12];
    logic [15:0] yw, uw, vw;
    int yv, uv, vv;
    for (int k = 0; k < 4; k++) begin
      yw = (k < 2) ? mem[int'(Y_B) + 2*g] : mem[int'(Y_B) + 2*g + 1];
      uw = mem[int'(U_B) + g];
      vw = mem[int'(V_B) + g];
      yv = int'((k % 2 == 0) ? yw[15:8] : yw[7:0]) - 16;
      uv = int'((k < 2) ? uw[15:8] : uw[7:0]) - 128;
      vv = int'((k < 2) ? vw[15:8] : vw[7:0]) - 128;
      stream[3*k]   = 8'(clip8((76284*yv + 104595*vv) >>> 16));
      stream[3*k+1] = 8'(clip8((76284*yv - 25624*uv - 53281*vv) >>> 16));
      stream[3*k+2] = 8'(clip8((76284*yv + 132251*uv) >>> 16));
    end
    return {stream[2*i], stream[2*i+1]};
  endfunction

  task automatic applyStimulus(input int mode);
    for (int g = 0; g < N; g++) begin
      case (mode)
        0: begin
          mem[int'(Y_B) + 2*g] = 16'h1010; mem[int'(Y_B) + 2*g + 1] = 16'h1010;
          mem[int'(U_B) + g] = 16'h8080;   mem[int'(V_B) + g] = 16'h8080;
        end
        1: begin
          mem[int'(Y_B) + 2*g] = 16'hEBEB; mem[int'(Y_B) + 2*g + 1] = 16'hEBEB;
          mem[int'(U_B) + g] = 16'h8080;   mem[int'(V_B) + g] = 16'h8080;
        end
        default: begin
          mem[int'(Y_B) + 2*g]     = 16'($urandom);
          mem[int'(Y_B) + 2*g + 1] = 16'($urandom);
          mem[int'(U_B) + g]       = 16'($urandom);
          mem[int'(V_B) + g]       = 16'($urandom);
        end
      endcase
    end
    if (mode == 2) begin
      mem[int'(Y_B)] = 16'hFF00;
      mem[int'(U_B)] = 16'h8080;
      mem[int'(V_B)] = 16'hFF80;
    end
  endtask

  // One full conversion; expected bus activity is a fixed 16-cycle schedule per group.
  task automatic runConversion(input bit spam);
    int g, p;
    logic [17:0] exp_addr;
    Start = 1'b1;
    for (int c = 0; c < 16*N; c++) begin
      @(negedge Clock);
      Start = 1'b0;
      g = c / 16;
      p = c % 16;
      checkOutput($sformatf("busy c%0d", c), 32'(Busy), 32'd1);
      checkOutput($sformatf("we_n c%0d", c), 32'(SRAM_we_n), (p >= 10) ? 32'd0 : 32'd1);
      if (p < 4 || p >= 10) begin
        case (p)
          0:       exp_addr = 18'(int'(Y_B) + 2*g);
          1:       exp_addr = 18'(int'(Y_B) + 2*g + 1);
          2:       exp_addr = 18'(int'(U_B) + g);
          3:       exp_addr = 18'(int'(V_B) + g);
          default: exp_addr = 18'(int'(RGB_B) + 6*g + p - 10);
        endcase
        checkOutput($sformatf("addr g%0d p%0d", g, p), 32'(SRAM_address), 32'(exp_addr));
      end
      if (p >= 10)
        checkOutput($sformatf("wdata g%0d w%0d", g, p - 10), 32'(SRAM_write_data), 32'(expWord(g, p - 10)));
      if (spam && c == 20)
        Start = 1'b1;
    end
    @(negedge Clock);
    checkOutput("done pulse", 32'(Done), 32'd1);
    Start = spam;
    @(negedge Clock);
    Start = 1'b0;
    checkOutput("done single", 32'(Done), 32'd0);
    checkOutput("idle busy", 32'(Busy), 32'd0);
    @(negedge Clock);
    checkOutput("idle we_n", 32'(SRAM_we_n), 32'd1);
    checkOutput("no restart", 32'(Busy), 32'd0);
  endtask

  initial begin
    Resetn = 1'b0;
    Start  = 1'b0;
    for (int a = 0; a < 262144; a++) mem[a] = 16'd0;
    repeat (2) @(negedge Clock);
    checkOutput("rst busy", 32'(Busy), 32'd0);
    checkOutput("rst done", 32'(Done), 32'd0);
    checkOutput("rst we_n", 32'(SRAM_we_n), 32'd1);
    checkOutput("rst addr", 32'(SRAM_address), 32'd0);
    checkOutput("rst wdata", 32'(SRAM_write_data), 32'd0);
    Resetn = 1'b1;
    @(negedge Clock);

    applyStimulus(0);
    runConversion(1'b0);
    applyStimulus(1);
    runConversion(1'b0);
    applyStimulus(2);
    runConversion(1'b1);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(3);
      runConversion(r[0]);
    end

    // Abort in group 1 WR3, then restart from group 0.
    applyStimulus(3);
    Start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    checkOutput("pre-abort we_n", 32'(SRAM_we_n), 32'd0);
    #1 Resetn = 1'b0;
    #1;
    checkOutput("abort we_n", 32'(SRAM_we_n), 32'd1);
    checkOutput("abort busy", 32'(Busy), 32'd0);
    checkOutput("abort addr", 32'(SRAM_address), 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    runConversion(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
